// File: rtl/sqgendemo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqgendemo_pkg
// Description : Shared constants for the square-wave note generator: counter
//               width, note half-periods, and the volume amplitude table.
// Revision    : 1.0 - initial release
// ============================================================================
package sqgendemo_pkg;

    localparam int c_cnt_w  = 16;
    localparam int c_clk_hz = 25_000_000;

    // Half-period divisors are twice the tone frequency.
    localparam int c_div_a4  = 880;
    localparam int c_div_cs5 = 1108;
    localparam int c_div_e5  = 1318;

    localparam int c_hp_a4  = c_clk_hz / c_div_a4;   // 28409
    localparam int c_hp_cs5 = c_clk_hz / c_div_cs5;  // 22563
    localparam int c_hp_e5  = c_clk_hz / c_div_e5;   // 18968

    typedef enum logic [1:0] {
        NOTE_SILENT = 2'd0,
        NOTE_A4     = 2'd1,
        NOTE_CS5    = 2'd2,
        NOTE_E5     = 2'd3
    } note_e;

    // Indexed directly by volsel.
    localparam logic [3:0][7:0] c_amp_table = {8'd255, 8'd127, 8'd63, 8'd31};

    // 0 when no bit is set, otherwise the position of the highest set bit plus one.
    function automatic logic [2:0] octave_shift(input logic [5:0] oct);
        logic [2:0] shift;
        shift = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (oct[i]) shift = 3'(i + 1);
        end
        return shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sq_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : sq_tone_gen
// Description : Half-period counter that toggles a phase bit, with restart.
// Revision    : 1.0 - initial release
// ============================================================================
module sq_tone_gen
    import sqgendemo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_restart,
    input  logic [c_cnt_w-1:0] i_half_period,
    output logic               o_phase
);

    logic [c_cnt_w-1:0] r_count;
    logic               r_phase;
    logic               w_last;

    assign w_last  = (r_count == (i_half_period - c_cnt_w'(1)));
    assign o_phase = r_phase;

    // Silence dominates restart; a restart always begins on the high half.
    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (i_restart) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else if (w_last) begin
            r_count <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sqgendemo_core.sv
`default_nettype none
// ============================================================================
// Module      : sqgendemo_core
// Description : Three-note square-wave generator with octave shift and volume.
// Revision    : 1.0 - initial release
// ============================================================================
module sqgendemo_core
    import sqgendemo_pkg::*;
#(
    parameter int CLK_HZ = c_clk_hz,
    parameter int HP_A4  = CLK_HZ / c_div_a4,
    parameter int HP_CS5 = CLK_HZ / c_div_cs5,
    parameter int HP_E5  = CLK_HZ / c_div_e5
) (
    input  logic       clk,
    input  logic       butt_1,
    input  logic       butt_2,
    input  logic       butt_3,
    input  logic       butt_4,
    input  logic [5:0] oct,
    input  logic [1:0] volsel,
    output logic [7:0] audio_out
);

    localparam logic [c_cnt_w-1:0] c_hp_a4_v  = c_cnt_w'(HP_A4);
    localparam logic [c_cnt_w-1:0] c_hp_cs5_v = c_cnt_w'(HP_CS5);
    localparam logic [c_cnt_w-1:0] c_hp_e5_v  = c_cnt_w'(HP_E5);

    note_e              w_note;
    logic [2:0]         w_shift;
    logic [c_cnt_w-1:0] w_base;
    logic [c_cnt_w-1:0] w_shifted;
    logic [c_cnt_w-1:0] w_half;
    logic               w_enable;
    logic               w_restart;
    logic               w_phase;

    note_e              r_note;
    logic [2:0]         r_shift;
    logic [7:0]         r_audio;

    always_comb begin
        w_note = NOTE_SILENT;
        if (butt_1)      w_note = NOTE_A4;
        else if (butt_2) w_note = NOTE_CS5;
        else if (butt_3) w_note = NOTE_E5;
    end

    always_comb begin
        w_base = '0;
        case (w_note)
            NOTE_A4:  w_base = c_hp_a4_v;
            NOTE_CS5: w_base = c_hp_cs5_v;
            NOTE_E5:  w_base = c_hp_e5_v;
            default:  w_base = '0;
        endcase
    end

    assign w_shift   = octave_shift(oct);
    assign w_shifted = w_base >> w_shift;
    assign w_half    = (w_shifted == '0) ? c_cnt_w'(1) : w_shifted;
    assign w_enable  = (w_note != NOTE_SILENT);
    // Reset parks r_note at silent so a held button restarts the tone afterwards.
    assign w_restart = (w_note != r_note) || (w_shift != r_shift);

    sq_tone_gen u_tone (
        .clk           (clk),
        .rst           (butt_4),
        .i_enable      (w_enable),
        .i_restart     (w_restart),
        .i_half_period (w_half),
        .o_phase       (w_phase)
    );

    always_ff @(posedge clk) begin
        if (butt_4) begin
            r_note  <= NOTE_SILENT;
            r_shift <= 3'd0;
            r_audio <= 8'd0;
        end else begin
            r_note  <= w_note;
            r_shift <= w_shift;
            r_audio <= w_phase ? c_amp_table[volsel] : 8'd0;
        end
    end

    assign audio_out = r_audio;

endmodule
`default_nettype wire

// File: tb/tb_sqgendemo_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqgendemo_core
// Description : Scoreboard bench for sqgendemo_core against a tone-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqgendemo_core;

    logic       clk = 1'b0;
    logic       butt_1 = 1'b0, butt_2 = 1'b0, butt_3 = 1'b0, butt_4 = 1'b1;
    logic [5:0] oct = 6'd0;
    logic [1:0] volsel = 2'd3;
    logic [7:0] audio_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    // Model: a tone is (note, shift) plus elapsed edges since it started.
    bit m_phase = 1'b0;
    bit m_valid = 1'b0;
    int m_note  = 0;
    int m_shift = 0;
    int m_k     = 0;

    sqgendemo_core dut (
        .clk       (clk),
        .butt_1    (butt_1),
        .butt_2    (butt_2),
        .butt_3    (butt_3),
        .butt_4    (butt_4),
        .oct       (oct),
        .volsel    (volsel),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    function automatic int amp_of(input logic [1:0] v);
        case (v)
            2'd0:    return 31;
            2'd1:    return 63;
            2'd2:    return 127;
            default: return 255;
        endcase
    endfunction

    function automatic int shift_of(input logic [5:0] o);
        int s = 0;
        for (int i = 0; i < 6; i++) if (o[i]) s = i + 1;
        return s;
    endfunction

    function automatic int base_of(input int n);
        case (n)
            1:       return 28409;
            2:       return 22563;
            default: return 18968;
        endcase
    endfunction

    task automatic model_push();
        int note, s, hp;
        logic [7:0] e;
        e = (!butt_4 && m_phase) ? 8'(amp_of(volsel)) : 8'd0;
        exp_q.push_back(e);
        note = butt_1 ? 1 : butt_2 ? 2 : butt_3 ? 3 : 0;
        if (butt_4 || note == 0) begin
            m_phase = 1'b0;
            m_valid = 1'b0;
        end else begin
            s = shift_of(oct);
            if (!m_valid || note != m_note || s != m_shift) m_k = 0;
            else m_k++;
            hp = base_of(note) >> s;
            if (hp < 1) hp = 1;
            m_phase = ((m_k / hp) % 2) == 0;
            m_note  = note;
            m_shift = s;
            m_valid = 1'b1;
        end
    endtask

    task automatic drive(input logic b4, input logic b1, input logic b2, input logic b3,
                         input logic [5:0] o, input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            butt_4 = b4; butt_1 = b1; butt_2 = b2; butt_3 = b3; oct = o; volsel = v;
            model_push();
        end
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (audio_out !== e) begin
                    n_errors++;
                    $display("FAIL audio_out at %0t: got %0d, expected %0d", $time, audio_out, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0] v;
        logic [2:0] b;
        logic [5:0] o;
        int len;
        drive(1, 1, 0, 0, 6'd0, 2'd3, 2);            // reset with button held
        drive(0, 1, 0, 0, 6'd0, 2'd3, 57000);        // full A4 period, default octave
        drive(0, 1, 0, 0, 6'b100000, 2'd3, 1000);    // octave jump mid-tone
        drive(0, 1, 0, 0, 6'b100000, 2'd1, 1000);    // volume change only
        drive(1, 1, 0, 0, 6'b100000, 2'd1, 1);       // reset pulse mid-tone
        drive(0, 1, 0, 0, 6'b100000, 2'd1, 500);
        drive(0, 1, 1, 0, 6'b100000, 2'd2, 1000);    // priority A4 over C#5
        drive(0, 0, 1, 0, 6'b100000, 2'd2, 1000);    // release A4 -> C#5
        drive(0, 0, 0, 0, 6'b100000, 2'd2, 5);       // silence
        for (int seg = 0; seg < 30; seg++) begin
            b = 3'($urandom_range(0, 7));
            v = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       o = 6'd0;
                1:       o = 6'(1 << $urandom_range(3, 5));
                default: o = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                drive(1, b[0], b[1], b[2], o, v, 1);
            end else begin
                len = $urandom_range(1, 1000);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 299) == 0) v = 2'($urandom_range(0, 3));
                    drive(0, b[0], b[1], b[2], o, v, 1);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
